// File: rtl/demux1_4_64bit_stream.sv
// Registered 1-to-4 word distributor. One word per cycle is steered into
// one of four single-entry lane registers, chosen by sel or by a
// round-robin pointer. Each lane has its own valid/ready handshake.
module demux1_4_64bit_stream #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         sel,
  input  logic               auto_mode,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out,
  output logic [1:0]         next_lane
);

  logic [WIDTH-1:0] lane_buf [4];
  logic [1:0]       target;
  logic             accept;

  // Target lane and input handshake; a full lane that is popping this
  // cycle can take a new word without a bubble.
  always_comb begin
    target   = auto_mode ? next_lane : sel;
    in_ready = !reset && (!out_valid[target] || out_ready[target]);
    accept   = in_valid && in_ready;
  end

  // Lane registers: a load on a lane wins over its own pop, so
  // simultaneous pop+load keeps the lane valid with the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= '0;
      for (int unsigned i = 0; i < 4; i++) lane_buf[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (accept && (target == 2'(i))) begin
          lane_buf[i]  <= in_data;
          out_valid[i] <= 1'b1;
        end else if (out_valid[i] && out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances only on accepted auto-mode words.
  always_ff @(posedge clk) begin
    if (reset)
      next_lane <= '0;
    else if (accept && auto_mode)
      next_lane <= next_lane + 2'd1;
  end

  // Pack lanes onto the output bus, lane i at [WIDTH*i +: WIDTH].
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < 4; i++) out[WIDTH*i +: WIDTH] = lane_buf[i];
  end

endmodule

// File: tb/tb_demux1_4_64bit_stream.sv
// Directed bench for demux1_4_64bit_stream with a reference model and a
// scoreboard of accepted words checked as each lane pops.
module tb_demux1_4_64bit_stream;

  localparam int unsigned W = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [1:0]     sel;
  logic           auto_mode;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out;
  logic [1:0]     next_lane;

  demux1_4_64bit_stream #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .auto_mode(auto_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .next_lane(next_lane)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   lane;
    logic [W-1:0] data;
  } sb_entry_t;

  sb_entry_t    sb [$];
  logic [3:0]   m_valid;
  logic [W-1:0] m_buf [4];
  logic [1:0]   m_ptr;
  int           checks;
  int           failures;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = '0;
    m_ptr   = '0;
    for (int i = 0; i < 4; i++) m_buf[i] = '0;
    sb.delete();
  endtask

  // Pop the oldest scoreboard entry for a lane and compare with the DUT lane.
  task automatic sb_pop(input int lane);
    int idx;
    idx = -1;
    for (int k = 0; k < sb.size(); k++)
      if (idx < 0 && sb[k].lane == 2'(lane)) idx = k;
    if (idx < 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      chk($sformatf("pop_lane%0d", lane), out[W*lane +: W], sb[idx].data);
      sb.delete(idx);
    end
  endtask

  // One clock of stimulus: drive, check combinational handshake and pops,
  // clock, advance model, check registered state.
  task automatic step(input bit iv, input logic [W-1:0] d, input logic [1:0] s,
                      input bit am, input logic [3:0] ordy, input bit rst);
    logic [1:0]     tgt;
    bit             exp_rdy, acc;
    logic [4*W-1:0] exp_out;
    sb_entry_t      e;
    in_valid = iv; in_data = d; sel = s; auto_mode = am; out_ready = ordy; reset = rst;
    #2;
    tgt     = am ? m_ptr : s;
    exp_rdy = !rst && (!m_valid[tgt] || ordy[tgt]);
    acc     = iv && exp_rdy;
    chk("in_ready", in_ready, exp_rdy);
    if (!rst)
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && ordy[i]) sb_pop(i);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && ordy[i]) m_valid[i] = 1'b0;
      if (acc) begin
        m_buf[tgt]   = d;
        m_valid[tgt] = 1'b1;
        e.lane = tgt; e.data = d;
        sb.push_back(e);
        if (am) m_ptr = m_ptr + 2'd1;
      end
    end
    exp_out = '0;
    for (int i = 0; i < 4; i++) exp_out[W*i +: W] = m_buf[i];
    chk("out_valid", out_valid, m_valid);
    chk("out", out, exp_out);
    chk("next_lane", next_lane, m_ptr);
  endtask

  initial begin
    checks = 0; failures = 0;
    in_valid = 0; in_data = '0; sel = '0; auto_mode = 0; out_ready = '0; reset = 1;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    step(0, '0, 0, 0, 4'h0, 1);
    step(0, '0, 0, 0, 4'h0, 1);
    chk("rst_out_valid", out_valid, 4'b0000);

    // 1: single word into lane 2, held while out_ready low
    step(1, 64'hccc, 2, 0, 4'h0, 0);
    chk("t1_valid", out_valid, 4'b0100);
    chk("t1_lane2", out[191:128], 64'hccc);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 4'h0, 0);
    chk("t1_hold", out[191:128], 64'hccc);

    // 2: full lane blocks, another lane accepts
    step(1, 64'h999, 2, 0, 4'h0, 0);
    step(1, 64'haaa, 0, 0, 4'h0, 0);
    chk("t2_valid", out_valid, 4'b0101);
    chk("t2_lane0", out[63:0], 64'haaa);

    // 3: pop and reload the same lane with no bubble
    step(1, 64'hbbb, 1, 0, 4'h0, 0);
    step(1, 64'h111, 1, 0, 4'b0010, 0);
    chk("t3_valid1", out_valid[1], 1'b1);
    chk("t3_lane1", out[127:64], 64'h111);
    step(0, '0, 0, 0, 4'hF, 0);
    chk("t3_drained", out_valid, 4'b0000);

    // 4: round-robin streaming with all consumers ready
    step(1, 64'haaa, 0, 1, 4'hF, 0);
    step(1, 64'hbbb, 0, 1, 4'hF, 0);
    step(1, 64'hccc, 0, 1, 4'hF, 0);
    step(1, 64'hddd, 0, 1, 4'hF, 0);
    chk("t4_lane3", out[255:192], 64'hddd);
    step(1, 64'heee, 0, 1, 4'hF, 0);
    chk("t4_lane0", out[63:0], 64'heee);
    chk("t4_ptr", next_lane, 2'd1);
    step(0, '0, 0, 1, 4'hF, 0);

    // 5: round-robin stall on a full lane, then release lane 0
    step(0, '0, 0, 0, 4'h0, 1);
    step(1, 64'h501, 0, 1, 4'h0, 0);
    step(1, 64'h502, 0, 1, 4'h0, 0);
    step(1, 64'h503, 0, 1, 4'h0, 0);
    step(1, 64'h504, 0, 1, 4'h0, 0);
    step(1, 64'h505, 0, 1, 4'h0, 0);
    chk("t5_stall_ptr", next_lane, 2'd0);
    step(1, 64'h505, 0, 1, 4'b0001, 0);
    chk("t5_lane0", out[63:0], 64'h505);
    chk("t5_valid", out_valid, 4'b1111);

    // 6: reset mid-stream with all lanes full; word during reset dropped
    step(1, 64'h123, 1, 0, 4'h0, 1);
    chk("t6_out", out, '0);
    step(0, '0, 0, 0, 4'h0, 0);
    chk("t6_valid", out_valid, 4'b0000);
    step(1, 64'h777, 3, 0, 4'h0, 0);
    step(0, '0, 0, 0, 4'hF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
